umsg_hint_data_sequencer: RTL



---
 rtl/umsg_hint_data_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/umsg_hint_data_sequencer.sv
// umsg_hint_data_sequencer: per-slot UMsg timers/FSMs emitting hint and data beats
// onto a single registered RX0 response stage with hint-first round-robin selection.
module umsg_hint_data_sequencer #(
    parameter int NUM_UMSG   = 8,
    parameter int ID_W       = $clog2(NUM_UMSG),
    parameter int TIMER_W    = 8,
    parameter int HINT_DELAY = 4,
    parameter int DATA_DELAY = 8,
    parameter int DATA_W     = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                umsg_wr_valid,
    input  logic [ID_W-1:0]     umsg_wr_id,
    input  logic [DATA_W-1:0]   umsg_wr_data,
    input  logic [NUM_UMSG-1:0] umsg_hint_en,
    output logic                rx_valid,
    output logic [27:0]         rx_hdr,
    output logic [DATA_W-1:0]   rx_data,
    input  logic                rx_ready,
    output logic [NUM_UMSG-1:0] slot_busy
);
    typedef enum logic [2:0] {
        UMsg_Idle, UMsg_ChangeOccured, UMsg_SendHint, UMsg_Waiting, UMsg_SendData
    } umsg_state_e;

    umsg_state_e         state [NUM_UMSG];
    logic [TIMER_W-1:0]  timer [NUM_UMSG];
    logic [DATA_W-1:0]   data  [NUM_UMSG];
    logic [ID_W-1:0]     ptr;
    logic [NUM_UMSG-1:0] hint_rdy, data_rdy, wr, pop;
    logic [ID_W-1:0]     sel_id, ix;
    logic                sel_hint, found, load;
    int                  idx;

    always_comb begin
        hint_rdy  = '0;
        data_rdy  = '0;
        slot_busy = '0;
        wr        = '0;
        pop       = '0;
        sel_id    = '0;
        found     = 1'b0;
        idx       = 0;
        ix        = '0;
        for (int k = 0; k < NUM_UMSG; k++) begin
            hint_rdy[k]  = state[k] == UMsg_SendHint && timer[k] == '0;
            data_rdy[k]  = state[k] == UMsg_SendData;
            slot_busy[k] = state[k] != UMsg_Idle;
            wr[k]        = umsg_wr_valid && 32'(umsg_wr_id) == k;
        end
        sel_hint = |hint_rdy;
        // Scan starts at ptr, which always points one past the last grant.
        for (int i = 0; i < NUM_UMSG; i++) begin
            idx = int'(ptr) + i;
            idx = idx >= NUM_UMSG ? idx - NUM_UMSG : idx;
            ix  = ID_W'(idx);
            if (!found && (sel_hint ? hint_rdy[ix] : data_rdy[ix])) begin
                sel_id = ix;
                found  = 1'b1;
            end
        end
        load = (|hint_rdy || |data_rdy) && (!rx_valid || rx_ready);
        for (int k = 0; k < NUM_UMSG; k++)
            pop[k] = load && sel_id == ID_W'(k);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_UMSG; k++) begin
                state[k] <= UMsg_Idle;
                timer[k] <= '0;
                data[k]  <= '0;
            end
            ptr      <= '0;
            rx_valid <= 1'b0;
            rx_hdr   <= '0;
            rx_data  <= '0;
        end else begin
            for (int k = 0; k < NUM_UMSG; k++) begin
                if (wr[k])
                    data[k] <= umsg_wr_data;
                case (state[k])
                    UMsg_Idle: if (wr[k]) state[k] <= UMsg_ChangeOccured;
                    UMsg_ChangeOccured: begin
                        timer[k] <= umsg_hint_en[k] ? TIMER_W'(HINT_DELAY) : TIMER_W'(DATA_DELAY);
                        state[k] <= umsg_hint_en[k] ? UMsg_SendHint : UMsg_Waiting;
                    end
                    UMsg_SendHint:
                        if (pop[k]) begin
                            timer[k] <= TIMER_W'(DATA_DELAY);
                            state[k] <= UMsg_Waiting;
                        end else if (timer[k] != '0)
                            timer[k] <= timer[k] - 1'b1;
                    UMsg_Waiting:
                        if (timer[k] == '0)
                            state[k] <= UMsg_SendData;
                        else
                            timer[k] <= timer[k] - 1'b1;
                    // A write landing on the pop cycle re-arms the slot instead of idling it.
                    UMsg_SendData: if (pop[k]) state[k] <= wr[k] ? UMsg_ChangeOccured : UMsg_Idle;
                    default: state[k] <= UMsg_Idle;
                endcase
            end
            if (load) begin
                rx_valid <= 1'b1;
                rx_hdr   <= {8'h00, 4'hF, 3'b000, sel_hint, 12'(sel_id)};
                rx_data  <= sel_hint ? '0 : data[sel_id];
                ptr      <= 32'(sel_id) == NUM_UMSG - 1 ? '0 : sel_id + 1'b1;
            end else if (rx_ready)
                rx_valid <= 1'b0;
        end
    end
endmodule
